// File: rtl/sample_player_pwm.sv
// Audio sample player: walks a sample ROM at a programmable rate, scales each
// sample by a volume setting and drives a registered PWM output.
module sample_player_pwm #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16,
  parameter int DIV_W  = 16,
  parameter int VOL_W  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_enable,
  input  logic              i_start,
  input  logic              i_loop_mode,
  input  logic [ADDR_W-1:0] i_start_addr,
  input  logic [ADDR_W-1:0] i_end_addr,
  input  logic [DIV_W-1:0]  i_sample_div,
  input  logic [VOL_W-1:0]  i_volume,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [DATA_W-1:0] i_rom_data,
  output logic              o_pwm,
  output logic              o_busy,
  output logic              o_done
);

  localparam int PROD_W = DATA_W + VOL_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_LAST = 2'd2
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_pwm_cnt;
  logic [DATA_W-1:0] r_duty;
  logic              r_pwm;
  logic [DIV_W-1:0]  r_div_cnt;
  logic [DIV_W-1:0]  r_div_lat;
  logic [ADDR_W-1:0] r_start_lat;
  logic [ADDR_W-1:0] r_end_lat;
  logic [ADDR_W-1:0] r_rom_addr;
  logic              r_busy;
  logic              r_done;

  logic              w_start_ok;
  logic              w_tick;
  logic              w_at_end;
  logic [VOL_W:0]    w_gain;
  logic [PROD_W-1:0] w_prod;
  logic [DATA_W-1:0] w_scaled;
  logic [DIV_W-1:0]  w_div_lat_in;

  assign w_start_ok   = (r_state == S_IDLE) && i_start && i_enable;
  assign w_tick       = (r_div_cnt == r_div_lat);
  assign w_at_end     = (r_rom_addr == r_end_lat);
  assign w_div_lat_in = (i_sample_div == '0) ? DIV_W'(1) : i_sample_div;

  // volume+1 so that all-ones volume is exactly unity gain after the shift
  assign w_gain   = {1'b0, i_volume} + (VOL_W+1)'(1);
  assign w_prod   = {{(VOL_W+1){1'b0}}, i_rom_data} * {{DATA_W{1'b0}}, w_gain};
  assign w_scaled = DATA_W'(w_prod >> VOL_W);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pwm_cnt <= '0;
      r_pwm     <= 1'b0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + DATA_W'(1);
      r_pwm     <= (r_pwm_cnt < r_duty);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div_cnt <= '0;
    end else if (w_start_ok || w_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_duty      <= '0;
      r_div_lat   <= '0;
      r_start_lat <= '0;
      r_end_lat   <= '0;
      r_rom_addr  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_duty <= '0;
          r_busy <= 1'b0;
          if (w_start_ok) begin
            r_start_lat <= i_start_addr;
            r_end_lat   <= i_end_addr;
            r_div_lat   <= w_div_lat_in;
            r_rom_addr  <= i_start_addr;
            r_busy      <= 1'b1;
            r_state     <= S_PLAY;
          end
        end
        S_PLAY: begin
          if (!i_enable) begin
            r_duty  <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_tick) begin
            r_duty <= w_scaled;
            if (w_at_end) begin
              if (i_loop_mode) begin
                r_rom_addr <= r_start_lat;
              end else begin
                r_state <= S_LAST;
              end
            end else begin
              r_rom_addr <= r_rom_addr + ADDR_W'(1);
            end
          end
        end
        S_LAST: begin
          // final sample keeps playing until the next tick closes its period
          if (!i_enable) begin
            r_duty  <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_tick) begin
            r_duty  <= '0;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_duty  <= '0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_rom_addr = r_rom_addr;
  assign o_pwm      = r_pwm;
  assign o_busy     = r_busy;
  assign o_done     = r_done;

endmodule

// File: tb/tb_sample_player_pwm.sv
// Bench for sample_player_pwm: directed scenarios plus randomized traffic,
// compared every cycle against a timeline-based playback model.
module tb_sample_player_pwm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        start = 1'b0;
  logic        loop_mode = 1'b0;
  logic [15:0] start_addr = '0;
  logic [15:0] end_addr = '0;
  logic [15:0] sample_div = '0;
  logic [3:0]  volume = '0;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data = '0;
  logic        pwm;
  logic        busy;
  logic        done;

  logic [7:0]  rom [0:65535];

  int n_total = 0;
  int n_bad   = 0;
  bit chk_en  = 1'b0;

  sample_player_pwm #(
    .DATA_W(8),
    .ADDR_W(16),
    .DIV_W (16),
    .VOL_W (4)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_enable    (enable),
    .i_start     (start),
    .i_loop_mode (loop_mode),
    .i_start_addr(start_addr),
    .i_end_addr  (end_addr),
    .i_sample_div(sample_div),
    .i_volume    (volume),
    .o_rom_addr  (rom_addr),
    .i_rom_data  (rom_data),
    .o_pwm       (pwm),
    .o_busy      (busy),
    .o_done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Playback model: samples fall on multiples of the period after the start
  // edge; the clip is tracked as a position offset from the latched start.
  int          edge_n = 0;
  int          m_t0, m_per, m_len, m_pos, m_duty, m_cnt;
  bit          m_active, m_final, m_pwm, m_busy, m_done;
  logic [15:0] m_start, m_addr, m_diff, m_ia;

  initial begin
    m_cnt = 0; m_duty = 0; m_active = 0; m_final = 0;
    m_pwm = 0; m_busy = 0; m_done = 0; m_addr = '0;
  end

  always @(posedge clk) begin
    edge_n++;
    m_pwm  = (m_cnt < m_duty);
    m_cnt  = (m_cnt + 1) % 256;
    m_done = 0;
    if (rst) begin
      m_cnt = 0; m_pwm = 0; m_duty = 0; m_addr = '0; m_active = 0;
    end else if (!m_active) begin
      m_duty = 0;
      if (start && enable) begin
        m_active = 1;
        m_t0     = edge_n;
        m_per    = ((sample_div == 0) ? 1 : int'(sample_div)) + 1;
        m_start  = start_addr;
        m_diff   = end_addr - start_addr;
        m_len    = int'(m_diff) + 1;
        m_pos    = 0;
        m_final  = 0;
        m_addr   = start_addr;
      end
    end else if (!enable) begin
      m_active = 0;
      m_duty   = 0;
    end else if ((edge_n - m_t0) % m_per == 0) begin
      if (m_final) begin
        m_duty = 0; m_done = 1; m_active = 0;
      end else begin
        m_ia   = m_start + 16'(m_pos);
        m_duty = ((int'(rom[m_ia]) * (int'(volume) + 1)) >> 4) & 255;
        if (m_pos == m_len - 1) begin
          if (loop_mode) m_pos = 0;
          else m_final = 1;
        end else begin
          m_pos++;
        end
        m_addr = m_start + 16'(m_pos);
      end
    end
    m_busy = m_active;
  end

  always @(negedge clk) begin
    if (chk_en) chk_eq("cyc", {rom_addr, pwm, busy, done}, {m_addr, m_pwm, m_busy, m_done});
  end

  logic [15:0] aq[$];
  int          kq[$];
  int          done_k, done_n, busy_n;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cfg(input logic [15:0] sa, input logic [15:0] ea, input logic [15:0] dv,
                     input logic [3:0] vol, input bit lp);
    start_addr = sa; end_addr = ea; sample_div = dv; volume = vol; loop_mode = lp;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic go_idle();
    enable = 1'b0;
    step(2);
    enable = 1'b1;
  endtask

  // act 1: drop loop_mode once the second pass reaches its second address
  // act 2: issue a start with new addresses while the clip is playing
  task automatic observe(input int max_k, input int act);
    logic [15:0] prev;
    aq.delete(); kq.delete();
    done_k = -1; done_n = 0; busy_n = 0;
    prev = rom_addr;
    aq.push_back(prev); kq.push_back(1);
    for (int k = 1; k <= max_k; k++) begin
      if (rom_addr !== prev) begin
        prev = rom_addr;
        aq.push_back(prev);
        kq.push_back(k);
      end
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_k < 0) done_k = k - 1;
      end
      if (act == 1 && aq.size() == 5) loop_mode = 1'b0;
      start = (act == 2 && k == 5);
      if (act == 2 && k == 5) begin
        start_addr = 16'd1000;
        end_addr   = 16'd2000;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  int exp3[6] = '{0, 1, 2, 0, 1, 2};
  int exp5[4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};

  initial begin
    int hi;
    int r;
    for (int i = 0; i < 65536; i++) rom[i] = 8'($urandom);

    rst = 1'b1; enable = 1'b1;
    step(1);
    chk_en = 1'b1;
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_addr", rom_addr, 0);
    chk_eq("rst_pwm",  pwm, 0);
    step(2);
    rst = 1'b0;
    step(2);

    // one-shot, three samples of ten clocks each
    rom[4] = 8'd10; rom[5] = 8'd200; rom[6] = 8'd255;
    cfg(16'd4, 16'd6, 16'd9, 4'd15, 1'b0);
    pulse_start();
    observe(60, 0);
    chk_eq("oneshot_done_at", done_k, 40);
    chk_eq("oneshot_busy_len", busy_n, 40);
    chk_eq("oneshot_done_cnt", done_n, 1);
    chk_eq("oneshot_addr_cnt", aq.size(), 3);

    // loop, then clear loop_mode during the second pass
    cfg(16'd0, 16'd2, 16'd3, 4'd15, 1'b1);
    pulse_start();
    observe(120, 1);
    chk_eq("loop_done_cnt", done_n, 1);
    chk_eq("loop_addr_cnt", aq.size(), 6);
    for (int i = 0; i < 6 && i < aq.size(); i++) chk_eq("loop_addr", aq[i], exp3[i]);

    // volume 7 on 200 -> duty 100, measured over one PWM frame
    rom[9] = 8'd200;
    cfg(16'd9, 16'd9, 16'd1, 4'd7, 1'b1);
    pulse_start();
    step(8);
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      if (pwm) hi++;
      step(1);
    end
    chk_eq("vol_pwm_high", hi, 100);
    go_idle();

    // sample_div 0 -> period 2, address wrap through zero
    cfg(16'hFFFE, 16'h0001, 16'd0, 4'd15, 1'b0);
    pulse_start();
    observe(30, 0);
    chk_eq("wrap_addr_cnt", aq.size(), 4);
    for (int i = 0; i < 4 && i < aq.size(); i++) chk_eq("wrap_addr", aq[i], exp5[i]);
    for (int i = 2; i < 4 && i < kq.size(); i++) chk_eq("wrap_period", kq[i] - kq[i-1], 2);
    chk_eq("wrap_done_at", done_k, 10);

    // single-sample one-shot clip
    cfg(16'd5, 16'd5, 16'd4, 4'd15, 1'b0);
    pulse_start();
    observe(30, 0);
    chk_eq("single_done_at", done_k, 10);
    chk_eq("single_busy_len", busy_n, 10);
    chk_eq("single_done_cnt", done_n, 1);
    chk_eq("single_addr_cnt", aq.size(), 1);

    // abort by enable low
    cfg(16'd20, 16'd40, 16'd2, 4'd15, 1'b0);
    pulse_start();
    step(10);
    enable = 1'b0;
    step(1);
    chk_eq("abort_busy", busy, 0);
    observe(40, 0);
    chk_eq("abort_done_cnt", done_n, 0);
    chk_eq("abort_pwm", pwm, 0);
    enable = 1'b1;

    // start while busy must not re-latch
    cfg(16'd50, 16'd53, 16'd3, 4'd15, 1'b0);
    pulse_start();
    observe(40, 2);
    chk_eq("busy_start_done_at", done_k, 20);
    chk_eq("busy_start_addr_cnt", aq.size(), 4);
    chk_eq("busy_start_last", aq[aq.size()-1], 53);

    // start with enable low is ignored
    enable = 1'b0;
    start_addr = 16'd7;
    pulse_start();
    step(3);
    chk_eq("dis_start_busy", busy, 0);
    chk_eq("dis_start_addr", rom_addr, 53);
    enable = 1'b1;

    // reset in the middle of looped playback
    cfg(16'd0, 16'd10, 16'd2, 4'd15, 1'b1);
    pulse_start();
    step(12);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk_eq("midrst_busy", busy, 0);
    chk_eq("midrst_addr", rom_addr, 0);
    chk_eq("midrst_pwm",  pwm, 0);
    observe(40, 0);
    chk_eq("midrst_done_cnt", done_n, 0);

    // randomized traffic, checked cycle by cycle against the model
    for (int it = 0; it < 40; it++) begin
      start_addr = 16'($urandom);
      end_addr   = start_addr + 16'($urandom_range(0, 5));
      sample_div = 16'($urandom_range(0, 4));
      volume     = 4'($urandom);
      loop_mode  = 1'($urandom_range(0, 1));
      enable     = 1'b1;
      pulse_start();
      for (int c = 0; c < 60; c++) begin
        r = $urandom_range(0, 99);
        enable = (r >= 3);
        start  = (r >= 3 && r < 6);
        if (r == 6) loop_mode = ~loop_mode;
        if (r >= 7 && r < 11) volume = 4'($urandom);
        rst = (r == 99);
        if (start) begin
          start_addr = 16'($urandom);
          end_addr   = start_addr + 16'($urandom_range(0, 5));
          sample_div = 16'($urandom_range(0, 3));
        end
        step(1);
      end
      start = 1'b0; rst = 1'b0;
      go_idle();
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
